// File: rtl/instr_pkg.sv
// Shared definitions for the instruction encoder.
// Holds the format codes, FSM state enum, field widths and opcode
// constants used by instr_encode and its 2-entry output buffer.
package instr_pkg;

  typedef enum logic [1:0] {
    FMT_R   = 2'b00,
    FMT_I   = 2'b01,
    FMT_J   = 2'b10,
    FMT_BAD = 2'b11
  } fmt_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_DRAIN = 2'b10
  } state_e;

  localparam int OPC_W   = 6;
  localparam int REG_W   = 5;
  localparam int SHAMT_W = 5;
  localparam int FUNCT_W = 6;
  localparam int IMM_W   = 16;
  localparam int JMP_W   = 26;
  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;
  localparam int ENTRY_W = ADDR_W + INSTR_W;

  localparam logic [OPC_W-1:0] OP_RTYPE = 6'd0;
  localparam logic [OPC_W-1:0] OP_J     = 6'd2;
  localparam logic [OPC_W-1:0] OP_ADDI  = 6'd8;

endpackage

// File: rtl/instr_fifo2.sv
// Two-entry first-word-fall-through buffer holding {Address, Instruction}.
// Ports:
//   clk, rst_n     clock and synchronous active-low reset (clears occupancy only)
//   push, wdata    write one entry (ignored when full)
//   pop            drop the head entry (ignored when empty)
//   rdata          head entry, valid while !empty
//   full, empty    occupancy flags
module instr_fifo2
  import instr_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic               pop,
  input  logic [ENTRY_W-1:0] wdata,
  output logic [ENTRY_W-1:0] rdata,
  output logic               full,
  output logic               empty
);

  logic [ENTRY_W-1:0] mem_q [2];
  logic [ENTRY_W-1:0] mem_d [2];
  logic               wr_ptr_q, wr_ptr_d;
  logic               rd_ptr_q, rd_ptr_d;
  logic [1:0]         cnt_q, cnt_d;
  logic               push_ok, pop_ok;

  assign full    = (cnt_q == 2'd2);
  assign empty   = (cnt_q == 2'd0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop_ok) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Storage carries no reset; the flags alone decide what is visible.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/instr_encode.sv
// Instruction encoder: packs R/I/J field sets into 32-bit words, pairs each
// with an auto-incrementing byte address and emits them through a 2-entry
// buffer with a valid/ready handshake.
// Ports:
//   Clk, Reset_n           clock, synchronous active-low reset
//   Start, Stop, Base_Addr run control and starting address
//   In_Valid/In_Ready      field-set handshake (Format, Opcode, R1..R3,
//                          Shamt, Funct, Immediate, Jump)
//   Out_Valid/Out_Ready    word handshake (Instruction, Address)
//   Count                  saturating count of words taken
//   Error                  sticky: an illegal field set was dropped
//   Busy                   FSM not idle
module instr_encode
  import instr_pkg::*;
(
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               Start,
  input  logic               Stop,
  input  logic [ADDR_W-1:0]  Base_Addr,
  input  logic               In_Valid,
  output logic               In_Ready,
  input  logic [1:0]         Format,
  input  logic [OPC_W-1:0]   Opcode,
  input  logic [REG_W-1:0]   R1,
  input  logic [REG_W-1:0]   R2,
  input  logic [REG_W-1:0]   R3,
  input  logic [SHAMT_W-1:0] Shamt,
  input  logic [FUNCT_W-1:0] Funct,
  input  logic [IMM_W-1:0]   Immediate,
  input  logic [JMP_W-1:0]   Jump,
  output logic               Out_Valid,
  input  logic               Out_Ready,
  output logic [INSTR_W-1:0] Instruction,
  output logic [ADDR_W-1:0]  Address,
  output logic [15:0]        Count,
  output logic               Error,
  output logic               Busy
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [15:0]         count_q, count_d;
  logic                error_q, error_d;

  logic [INSTR_W-1:0]  packed_word;
  logic                legal, accept, push, pop;
  logic                fifo_full, fifo_empty;
  logic [ENTRY_W-1:0]  fifo_rdata;

  always_comb begin
    packed_word = '0;
    case (Format)
      FMT_R:   packed_word = {OP_RTYPE, R1, R2, R3, Shamt, Funct};
      FMT_I:   packed_word = {Opcode, R1, R2, Immediate};
      FMT_J:   packed_word = {Opcode, Jump};
      default: packed_word = '0;
    endcase
  end

  assign legal = (Format == FMT_I) || (Format == FMT_J) ||
                 ((Format == FMT_R) && (Opcode == OP_RTYPE));

  // In_Ready looks only at flops, so Out_Ready never reaches it.
  assign In_Ready  = (state_q == ST_RUN) && !fifo_full;
  assign accept    = In_Valid && In_Ready;
  assign push      = accept && legal;
  assign Out_Valid = !fifo_empty;
  assign pop       = Out_Valid && Out_Ready;

  // Buffer data is unreset, so mask the head while nothing is held.
  assign Instruction = fifo_empty ? '0 : fifo_rdata[INSTR_W-1:0];
  assign Address     = fifo_empty ? '0 : fifo_rdata[ENTRY_W-1:INSTR_W];
  assign Count       = count_q;
  assign Error       = error_q;
  assign Busy        = (state_q != ST_IDLE);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    error_d = error_q;
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          state_d = ST_RUN;
          addr_d  = Base_Addr & ~32'h3;
        end
      end
      ST_RUN: begin
        if (Stop) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (fifo_empty) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (push) addr_d = addr_q + 32'd4;
    if (accept && !legal) error_d = 1'b1;
    if (pop && (count_q != 16'hFFFF)) count_d = count_q + 16'd1;
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      count_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      error_q <= error_d;
    end
  end

  instr_fifo2 u_fifo (
    .clk   (Clk),
    .rst_n (Reset_n),
    .push  (push),
    .pop   (pop),
    .wdata ({addr_q, packed_word}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_instr_encode.sv
module tb_instr_encode;
  import instr_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        Start = 1'b0, Stop = 1'b0;
  logic [31:0] Base_Addr = '0;
  logic        In_Valid = 1'b0;
  logic        In_Ready;
  logic [1:0]  Format = '0;
  logic [5:0]  Opcode = '0;
  logic [4:0]  R1 = '0, R2 = '0, R3 = '0, Shamt = '0;
  logic [5:0]  Funct = '0;
  logic [15:0] Immediate = '0;
  logic [25:0] Jump = '0;
  logic        Out_Valid;
  logic        Out_Ready = 1'b0;
  logic [31:0] Instruction, Address;
  logic [15:0] Count;
  logic        Error, Busy;

  always #5 Clk = ~Clk;

  instr_encode dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Stop(Stop),
    .Base_Addr(Base_Addr), .In_Valid(In_Valid), .In_Ready(In_Ready),
    .Format(Format), .Opcode(Opcode), .R1(R1), .R2(R2), .R3(R3),
    .Shamt(Shamt), .Funct(Funct), .Immediate(Immediate), .Jump(Jump),
    .Out_Valid(Out_Valid), .Out_Ready(Out_Ready), .Instruction(Instruction),
    .Address(Address), .Count(Count), .Error(Error), .Busy(Busy)
  );

  // Reference model: word queue plus plain counters.
  typedef struct { logic [31:0] a; logic [31:0] w; } ent_t;
  ent_t        mq[$];
  int          m_state = 0;  // 0 idle, 1 run, 2 drain
  logic [31:0] m_addr = '0;
  int          m_count = 0;
  bit          m_err = 0;
  int          checks = 0, errors = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_word();
    logic [31:0] w;
    if (Format == 2'd0)
      w = (32'(R1) << 21) + (32'(R2) << 16) + (32'(R3) << 11) + (32'(Shamt) << 6) + 32'(Funct);
    else if (Format == 2'd1)
      w = (32'(Opcode) << 26) + (32'(R1) << 21) + (32'(R2) << 16) + 32'(Immediate);
    else
      w = (32'(Opcode) << 26) + 32'(Jump);
    return w;
  endfunction

  // One clock: advance the model with the driven inputs, then compare.
  task automatic cycle();
    int  sz0;
    bit  rdy, acc, pp, ok;
    ent_t e;
    sz0 = mq.size();
    if (!Reset_n) begin
      mq.delete(); m_state = 0; m_addr = '0; m_count = 0; m_err = 0;
    end else begin
      rdy = (m_state == 1) && (sz0 < 2);
      acc = In_Valid && rdy;
      pp  = (sz0 > 0) && Out_Ready;
      ok  = (Format == 2'd1) || (Format == 2'd2) || (Format == 2'd0 && Opcode == 6'd0);
      if (pp) void'(mq.pop_front());
      if (acc && ok) begin
        e.a = m_addr; e.w = ref_word(); mq.push_back(e);
        m_addr = m_addr + 32'd4;
      end
      if (acc && !ok) m_err = 1;
      if (pp && m_count < 65535) m_count++;
      if (m_state == 0 && Start) begin
        m_state = 1; m_addr = {Base_Addr[31:2], 2'b00};
      end else if (m_state == 1 && Stop) m_state = 2;
      else if (m_state == 2 && sz0 == 0) m_state = 0;
    end
    @(posedge Clk);
    @(negedge Clk);
    chk("out_valid", 32'(Out_Valid), 32'(mq.size() > 0));
    chk("instruction", Instruction, mq.size() > 0 ? mq[0].w : 32'h0);
    chk("address", Address, mq.size() > 0 ? mq[0].a : 32'h0);
    chk("in_ready", 32'(In_Ready), 32'((m_state == 1) && (mq.size() < 2)));
    chk("count", 32'(Count), 32'(m_count));
    chk("error", 32'(Error), 32'(m_err));
    chk("busy", 32'(Busy), 32'(m_state != 0));
  endtask

  task automatic drive_r(logic [5:0] op, logic [4:0] a, logic [4:0] b, logic [4:0] c,
                         logic [4:0] sh, logic [5:0] fn);
    In_Valid = 1; Format = 2'd0; Opcode = op; R1 = a; R2 = b; R3 = c; Shamt = sh; Funct = fn;
  endtask

  task automatic drive_i(logic [5:0] op, logic [4:0] a, logic [4:0] b, logic [15:0] imm);
    In_Valid = 1; Format = 2'd1; Opcode = op; R1 = a; R2 = b; Immediate = imm;
  endtask

  task automatic drive_j(logic [5:0] op, logic [25:0] tgt);
    In_Valid = 1; Format = 2'd2; Opcode = op; Jump = tgt;
  endtask

  task automatic go_idle();
    Stop = 1; Out_Ready = 1; In_Valid = 0;
    cycle();
    Stop = 0;
    for (int k = 0; k < 8 && Busy; k++) cycle();
    chk("drain_to_idle", 32'(Busy), 32'h0);
  endtask

  initial begin
    logic [31:0] w0, a0;

    // Reset
    cycle(); cycle();
    chk("reset_count", 32'(Count), 32'h0);
    Reset_n = 1;
    cycle();

    // R-type
    Base_Addr = 32'h0040_0000; Start = 1; cycle(); Start = 0;
    Out_Ready = 1;
    drive_r(OP_RTYPE, 5'd9, 5'd10, 5'd8, 5'd0, 6'h20); cycle(); In_Valid = 0;
    chk("r_word", Instruction, 32'h012A_4020);
    chk("r_addr", Address, 32'h0040_0000);
    cycle();
    chk("r_count", 32'(Count), 32'd1);
    go_idle();

    // I and J back-to-back; Start must not clear Count
    Start = 1; cycle(); Start = 0;
    chk("count_kept", 32'(Count), 32'd1);
    Out_Ready = 0;
    drive_i(OP_ADDI, 5'd0, 5'd9, 16'd5); cycle();
    drive_j(OP_J, 26'h010_0000); cycle(); In_Valid = 0;
    chk("i_word", Instruction, 32'h2009_0005);
    chk("i_addr", Address, 32'h0040_0000);
    Out_Ready = 1; cycle();
    chk("j_word", Instruction, 32'h0810_0000);
    chk("j_addr", Address, 32'h0040_0004);
    cycle();

    // Backpressure with three words
    Out_Ready = 0;
    drive_i(6'd13, 5'd1, 5'd2, 16'h1111); w0 = ref_word(); cycle();
    drive_i(6'd13, 5'd3, 5'd4, 16'h2222); cycle();
    drive_i(6'd13, 5'd5, 5'd6, 16'h3333);
    chk("bp_not_ready", 32'(In_Ready), 32'h0);
    cycle(); cycle();
    chk("bp_hold", Instruction, w0);
    Out_Ready = 1; cycle(); cycle(); In_Valid = 0;
    cycle(); cycle(); cycle();

    // Rejections
    a0 = m_addr;
    In_Valid = 1; Format = 2'd3; cycle();
    drive_r(6'd4, 5'd1, 5'd1, 5'd1, 5'd0, 6'h20); cycle(); In_Valid = 0;
    chk("rej_error", 32'(Error), 32'h1);
    chk("rej_no_out", 32'(Out_Valid), 32'h0);
    drive_j(OP_J, 26'h00_0ABC); cycle(); In_Valid = 0;
    chk("rej_addr", Address, a0);
    cycle();
    go_idle();

    // Stop with second word, address wrap
    Base_Addr = 32'hFFFF_FFFF; Start = 1; Out_Ready = 0; cycle(); Start = 0;
    drive_i(OP_ADDI, 5'd2, 5'd3, 16'hFFFF); cycle();
    drive_j(OP_J, 26'h3FF_FFFF); Stop = 1; cycle(); Stop = 0; In_Valid = 0;
    chk("wrap_addr0", Address, 32'hFFFF_FFFC);
    cycle();
    Out_Ready = 1; cycle();
    chk("wrap_addr1", Address, 32'h0);
    cycle(); cycle();
    chk("stop_idle", 32'(Busy), 32'h0);
    chk("error_sticky", 32'(Error), 32'h1);

    // Reset with two words buffered
    Base_Addr = 32'h0000_1000; Start = 1; Out_Ready = 0; cycle(); Start = 0;
    drive_j(OP_J, 26'h1); cycle(); drive_j(OP_J, 26'h2); cycle(); In_Valid = 0;
    Reset_n = 0; cycle();
    chk("rst_valid", 32'(Out_Valid), 32'h0);
    chk("rst_count", 32'(Count), 32'h0);
    chk("rst_busy", 32'(Busy), 32'h0);
    Reset_n = 1; Out_Ready = 1; cycle();
    chk("rst_no_emit", 32'(Out_Valid), 32'h0);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      Reset_n   = ($urandom_range(0, 99) != 0);
      Start     = ($urandom_range(0, 7) == 0);
      Stop      = ($urandom_range(0, 15) == 0);
      Base_Addr = $urandom();
      In_Valid  = $urandom_range(0, 1);
      Format    = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      Opcode    = ($urandom_range(0, 3) == 0) ? 6'($urandom()) : 6'd0;
      R1 = 5'($urandom()); R2 = 5'($urandom()); R3 = 5'($urandom());
      Shamt = 5'($urandom()); Funct = 6'($urandom());
      Immediate = 16'($urandom()); Jump = 26'($urandom());
      Out_Ready = ($urandom_range(0, 2) != 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
